weight_loader: RTL and testbench

Fills the MLP weight BRAM. Accepts a byte stream of flattened row-major weights on a valid/ready handshake, packs `MAX_WEIGHTS_SIZE` bytes into one BRAM word, and writes each word to consecutive addresses starting at 0. It drives the BRAM write port (`wr_en`/`wr_addr`/`data_in`) that the MLP controller's read side consumes. It must complete before the controller is given `new_data`.

---
 rtl/mlp_pkg.sv | 13 +
 rtl/weight_word_packer.sv | 57 +++++
 rtl/weight_loader.sv | 125 ++++++++++++
 tb/tb_weight_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared MLP constants and weight loader state encoding
package mlp_pkg;
    localparam int DEF_DATA_SIZE        = 8;
    localparam int DEF_MAX_WEIGHTS_SIZE = 32;
    localparam int DEF_MEM_ADDR_WIDTH   = 3;

    typedef enum logic [3:0] {
        WL_IDLE  = 4'b0001,
        WL_FILL  = 4'b0010,
        WL_WRITE = 4'b0100,
        WL_DONE  = 4'b1000
    } weight_loader_state_t;
endpackage

// File: rtl/weight_word_packer.sv
// rtl/weight_word_packer.sv - gathers stream bytes into one BRAM word lane by lane
module weight_word_packer
    import mlp_pkg::*;
#(
    parameter int DATA_SIZE        = DEF_DATA_SIZE,
    parameter int MAX_WEIGHTS_SIZE = DEF_MAX_WEIGHTS_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 restart_i,
    input  logic                 push_i,
    input  logic                 zero_fill_i,
    input  logic [DATA_SIZE-1:0] data_i,
    output logic [DATA_SIZE-1:0] lanes_o [MAX_WEIGHTS_SIZE],
    output logic                 word_full_o
);
    localparam int CNT_W = (MAX_WEIGHTS_SIZE > 1) ? $clog2(MAX_WEIGHTS_SIZE) : 1;

    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [DATA_SIZE-1:0] lanes_q [MAX_WEIGHTS_SIZE];
    logic [DATA_SIZE-1:0] lanes_d [MAX_WEIGHTS_SIZE];

    assign lanes_o     = lanes_q;
    // High while the next accepted byte lands in the last lane.
    assign word_full_o = (byte_cnt_q == CNT_W'(MAX_WEIGHTS_SIZE - 1));

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        lanes_d    = lanes_q;
        if (clear_i) begin
            byte_cnt_d = '0;
            for (int i = 0; i < MAX_WEIGHTS_SIZE; i++) lanes_d[i] = '0;
        end else begin
            if (push_i) begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
                for (int i = 0; i < MAX_WEIGHTS_SIZE; i++) begin
                    if (CNT_W'(i) == byte_cnt_q)
                        lanes_d[i] = data_i;
                    else if (zero_fill_i && (CNT_W'(i) > byte_cnt_q))
                        lanes_d[i] = '0;
                end
            end
            if (restart_i) byte_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            for (int i = 0; i < MAX_WEIGHTS_SIZE; i++) lanes_q[i] <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            for (int i = 0; i < MAX_WEIGHTS_SIZE; i++) lanes_q[i] <= lanes_d[i];
        end
    end
endmodule

// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - streams flattened weights into consecutive MLP weight BRAM words
module weight_loader
    import mlp_pkg::*;
#(
    parameter int DATA_SIZE        = DEF_DATA_SIZE,
    parameter int MAX_WEIGHTS_SIZE = DEF_MAX_WEIGHTS_SIZE,
    parameter int MEM_ADDR_WIDTH   = DEF_MEM_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH:0]   num_words,
    input  logic                      s_valid,
    input  logic [DATA_SIZE-1:0]      s_data,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic                      wr_en,
    output logic [MEM_ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_SIZE-1:0]      wr_data [MAX_WEIGHTS_SIZE],
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    localparam logic [MEM_ADDR_WIDTH:0] CAPACITY = {1'b1, {MEM_ADDR_WIDTH{1'b0}}};
    localparam logic [MEM_ADDR_WIDTH:0] ONE      = {{MEM_ADDR_WIDTH{1'b0}}, 1'b1};

    weight_loader_state_t    state_q, state_d;
    logic [MEM_ADDR_WIDTH:0] num_words_q, num_words_d;
    logic [MEM_ADDR_WIDTH:0] word_cnt_q, word_cnt_d;
    logic                    error_q, error_d;
    logic                    end_q, end_d;
    logic                    pk_clear, pk_restart, pk_push, pk_zero_fill;
    logic                    word_full, last_word;

    assign s_ready   = (state_q == WL_FILL);
    assign wr_en     = (state_q == WL_WRITE);
    assign busy      = (state_q != WL_IDLE);
    assign done      = (state_q == WL_DONE);
    assign error     = error_q;
    assign wr_addr   = word_cnt_q[MEM_ADDR_WIDTH-1:0];
    assign pk_push   = s_valid && s_ready;
    assign last_word = (word_cnt_q == num_words_q - ONE);

    weight_word_packer #(
        .DATA_SIZE        (DATA_SIZE),
        .MAX_WEIGHTS_SIZE (MAX_WEIGHTS_SIZE)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (pk_clear),
        .restart_i   (pk_restart),
        .push_i      (pk_push),
        .zero_fill_i (pk_zero_fill),
        .data_i      (s_data),
        .lanes_o     (wr_data),
        .word_full_o (word_full)
    );

    always_comb begin
        state_d      = state_q;
        num_words_d  = num_words_q;
        word_cnt_d   = word_cnt_q;
        error_d      = error_q;
        end_d        = end_q;
        pk_clear     = 1'b0;
        pk_restart   = 1'b0;
        pk_zero_fill = 1'b0;
        case (state_q)
            WL_IDLE: begin
                if (start) begin
                    num_words_d = num_words;
                    word_cnt_d  = '0;
                    error_d     = 1'b0;
                    end_d       = 1'b0;
                    pk_clear    = 1'b1;
                    if (num_words == '0) begin
                        state_d = WL_DONE;
                    end else if (num_words > CAPACITY) begin
                        error_d = 1'b1;
                        state_d = WL_DONE;
                    end else begin
                        state_d = WL_FILL;
                    end
                end
            end
            WL_FILL: begin
                if (pk_push) begin
                    // s_last anywhere but the final lane of the final word truncates the session.
                    if (s_last && (!word_full || !last_word)) begin
                        error_d      = 1'b1;
                        end_d        = 1'b1;
                        pk_zero_fill = 1'b1;
                        state_d      = WL_WRITE;
                    end else if (word_full) begin
                        if (last_word && !s_last) error_d = 1'b1;
                        state_d = WL_WRITE;
                    end
                end
            end
            WL_WRITE: begin
                pk_restart = 1'b1;
                word_cnt_d = word_cnt_q + ONE;
                state_d    = (last_word || end_q) ? WL_DONE : WL_FILL;
            end
            WL_DONE: state_d = WL_IDLE;
            default: state_d = WL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WL_IDLE;
            num_words_q <= '0;
            word_cnt_q  <= '0;
            error_q     <= 1'b0;
            end_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_words_q <= num_words_d;
            word_cnt_q  <= word_cnt_d;
            error_q     <= error_d;
            end_q       <= end_d;
        end
    end
endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - directed sessions against a stream-level model of the loader
module tb_weight_loader;
    localparam int DW = 8;
    localparam int NL = 32;
    localparam int AW = 3;

    typedef logic [DW*NL-1:0] word_t;
    typedef struct {
        logic [AW-1:0] addr;
        word_t         data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [AW:0]     num_words = '0;
    logic            s_valid = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic            s_last = 1'b0;
    logic            s_ready, wr_en, busy, done, error;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data [NL];

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    wr_seen = 0;
    bit    exp_err;
    wr_t   exp_q[$];
    wr_t   cur;
    word_t got;
    word_t mem [1<<AW];
    logic [DW-1:0] bytes [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    weight_loader #(.DATA_SIZE(DW), .MAX_WEIGHTS_SIZE(NL), .MEM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error)
    );

    task automatic check(input string name, input logic [DW*NL-1:0] act, input logic [DW*NL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic word_t flat_wr();
        word_t f;
        for (int j = 0; j < NL; j++) f[j*DW +: DW] = wr_data[j];
        return f;
    endfunction

    function automatic logic [DW-1:0] lane(input word_t w, input int j);
        return w[j*DW +: DW];
    endfunction

    task automatic fill_bytes(input int base);
        for (int i = 0; i < 64; i++) bytes[i] = DW'(base + i);
    endtask

    // Byte i of the session belongs in word i/NL, lane i%NL; the session stops at the first
    // accepted s_last or after n*NL bytes, and only an s_last on exactly byte n*NL-1 is clean.
    task automatic model_session(input int n, input int last);
        int total, used;
        wr_t e;
        exp_q.delete();
        if (n == 0) begin
            exp_err = 1'b0;
        end else if (n > (1 << AW)) begin
            exp_err = 1'b1;
        end else begin
            total   = n * NL;
            used    = (last >= 0 && last < total) ? last + 1 : total;
            exp_err = (last != total - 1);
            for (int w = 0; w * NL < used; w++) begin
                e.addr = AW'(w);
                e.data = '0;
                for (int j = 0; j < NL; j++)
                    if (w * NL + j < used) e.data[j*DW +: DW] = bytes[w*NL + j];
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            got = flat_wr();
            mem[wr_addr] = got;
            wr_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got write at addr %0d expected none", wr_addr);
            end else begin
                cur = exp_q.pop_front();
                check("wr_addr", wr_addr, cur.addr);
                check("wr_data", got, cur.data);
            end
        end
    end

    task automatic drive(input int nb, input int last, input bit gaps, input int poke_at);
        int i, t;
        bit rdy, offered, poked;
        i = 0; t = 0; poked = 0;
        while (i < nb && t < 4000) begin
            offered = !(gaps && $urandom_range(0, 2) == 0);
            s_valid = offered;
            s_data  = bytes[i];
            s_last  = (i == last);
            if (i == poke_at && !poked) begin
                start = 1'b1;
                num_words = (AW+1)'(1);
                poked = 1;
            end
            rdy = s_ready;
            @(posedge clk);
            if (offered && rdy) i++;
            @(negedge clk);
            start = 1'b0;
            t++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("drive_bytes_accepted", i, nb);
    endtask

    task automatic run_session(input string tag, input int n, input int nb, input int last,
                               input bit gaps, input int poke_at, input int exp_span);
        int s, t, w0;
        model_session(n, last);
        w0 = wr_seen;
        @(negedge clk);
        start = 1'b1;
        num_words = (AW+1)'(n);
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        check({tag, ":busy_after_start"}, busy, 1);
        check({tag, ":ready_after_start"}, s_ready, (n >= 1 && n <= (1 << AW)));
        drive(nb, last, gaps, poke_at);
        t = 0;
        while (!done && t < 500) begin
            @(negedge clk);
            t++;
        end
        check({tag, ":done_seen"}, done, 1);
        if (exp_span >= 0) check({tag, ":start_to_done_cycles"}, cyc - s + 1, exp_span);
        check({tag, ":error"}, error, exp_err);
        check({tag, ":pending_writes"}, exp_q.size(), 0);
        check({tag, ":write_count"}, wr_seen - w0, (n >= 1 && n <= (1 << AW)) ?
              ((last >= 0 && last < n * NL) ? (last + NL) / NL : n) : 0);
        @(negedge clk);
        check({tag, ":done_one_cycle"}, done, 0);
        check({tag, ":idle_after_done"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset:s_ready", s_ready, 0);
        check("reset:wr_en", wr_en, 0);
        check("reset:wr_addr", wr_addr, 0);
        check("reset:wr_data", flat_wr(), 0);
        check("reset:busy", busy, 0);
        check("reset:done", done, 0);
        check("reset:error", error, 0);
        rst_n = 1'b1;

        fill_bytes(1);
        model_session(2, 63);
        check("model:full_words", exp_q.size(), 2);
        check("model:full_w1_lane0", lane(exp_q[1].data, 0), 33);
        check("model:full_w0_lane31", lane(exp_q[0].data, 31), 32);
        run_session("full", 2, 64, 63, 0, -1, 68);
        check("full:addr0_lane0", lane(mem[0], 0), 1);
        check("full:addr1_lane0", lane(mem[1], 0), 33);
        check("full:addr1_lane31", lane(mem[1], 31), 64);

        fill_bytes(1);
        run_session("gaps", 1, 32, 31, 1, -1, -1);
        check("gaps:addr0_lane31", lane(mem[0], 31), 32);

        fill_bytes(1);
        model_session(2, 39);
        check("model:early_w1_lane7", lane(exp_q[1].data, 7), 40);
        check("model:early_w1_lane8", lane(exp_q[1].data, 8), 0);
        run_session("early_last", 2, 40, 39, 0, -1, -1);
        check("early_last:addr1_lane7", lane(mem[1], 7), 40);
        check("early_last:addr1_lane8", lane(mem[1], 8), 0);
        check("early_last:addr1_lane31", lane(mem[1], 31), 0);

        fill_bytes(200);
        run_session("missing_last", 1, 32, -1, 0, -1, 35);
        check("missing_last:addr0_lane5", lane(mem[0], 5), 205);

        run_session("empty", 0, 0, -1, 0, -1, 2);
        run_session("too_many", 9, 0, -1, 0, -1, 2);
        repeat (3) @(negedge clk);
        check("too_many:error_sticky", error, 1);

        fill_bytes(50);
        run_session("start_while_busy", 2, 64, 63, 0, 10, 68);
        check("start_while_busy:addr1_lane31", lane(mem[1], 31), 113);

        fill_bytes(100);
        @(negedge clk);
        start = 1'b1;
        num_words = (AW+1)'(2);
        @(negedge clk);
        start = 1'b0;
        drive(20, -1, 0, -1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset:s_ready", s_ready, 0);
        check("midreset:wr_en", wr_en, 0);
        check("midreset:wr_addr", wr_addr, 0);
        check("midreset:wr_data", flat_wr(), 0);
        check("midreset:busy", busy, 0);
        check("midreset:done", done, 0);
        check("midreset:error", error, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fill_bytes(7);
        run_session("after_reset", 1, 32, 31, 0, -1, 35);
        check("after_reset:addr0_lane0", lane(mem[0], 0), 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
